// File: rtl/lvt_multiport_ram_if.sv
// Request/response bundle for lvt_multiport_ram: per-port write and read requests plus
// registered read data, init status and write-collision statistics.
`timescale 1ns/1ps
interface lvt_multiport_ram_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WPORTS = 4,
  parameter int unsigned RPORTS = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WPORTS-1:0]            wr_en;
  logic [WPORTS-1:0][AW-1:0]    wr_addr;
  logic [WPORTS-1:0][WIDTH-1:0] wr_data;
  logic [RPORTS-1:0]            rd_en;
  logic [RPORTS-1:0][AW-1:0]    rd_addr;
  logic [RPORTS-1:0][WIDTH-1:0] rd_data;
  logic [RPORTS-1:0]            rd_valid;
  logic                         init_done;
  logic                         collision;
  logic [15:0]                  collision_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_done, collision, collision_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_done, collision, collision_count
  );
endinterface

// File: rtl/lvt_multiport_ram.sv
// Multi-write/multi-read RAM from a WPORTS x RPORTS grid of 1W1R banks plus a live-value table.
// Optional macro LVT_WRITE_FORWARD_EN forwards same-cycle write data to colliding reads.
`timescale 1ns/1ps
module lvt_multiport_ram #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       DEPTH      = 512,
  parameter int unsigned       WPORTS     = 4,
  parameter int unsigned       RPORTS     = 4,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lvt_multiport_ram_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = ($clog2(WPORTS) > 1) ? $clog2(WPORTS) : 1;

  typedef enum logic {StInit, StRun} state_e;

  state_e                       r_state;
  logic [AW-1:0]                r_cnt;
  logic [RPORTS-1:0][WIDTH-1:0] r_rd_data;
  logic [RPORTS-1:0]            r_rd_valid;
  logic                         r_init_done;
  logic                         r_collision;
  logic [15:0]                  r_collision_count;

  logic [WIDTH-1:0]             r_bank [WPORTS][RPORTS][DEPTH];
  logic [LW-1:0]                r_lvt  [DEPTH];

  logic [WPORTS-1:0]            w_we;
  logic [WPORTS-1:0][AW-1:0]    w_waddr;
  logic [WPORTS-1:0][WIDTH-1:0] w_wdata;
  logic                         w_clash;
  logic [RPORTS-1:0][WIDTH-1:0] w_rd_word;

  // The init sweep hijacks every write port so all banks get INIT_VALUE at r_cnt.
  always_comb begin
    w_we    = '0;
    w_waddr = '0;
    w_wdata = '0;
    for (int w = 0; w < WPORTS; w++) begin
      if (r_state == StInit) begin
        w_we[w]    = 1'b1;
        w_waddr[w] = r_cnt;
        w_wdata[w] = INIT_VALUE;
      end else begin
        w_we[w]    = bus.wr_en[w];
        w_waddr[w] = bus.wr_addr[w];
        w_wdata[w] = bus.wr_data[w];
      end
    end
  end

  always_comb begin
    w_clash = 1'b0;
    for (int i = 0; i < WPORTS; i++) begin
      for (int j = i + 1; j < WPORTS; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] && (bus.wr_addr[i] == bus.wr_addr[j])) begin
          w_clash = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int r = 0; r < RPORTS; r++) begin
      w_rd_word[r] = r_bank[r_lvt[bus.rd_addr[r]]][r][bus.rd_addr[r]];
`ifdef LVT_WRITE_FORWARD_EN
      // Ascending scan leaves the highest-index matching writer, matching LVT arbitration.
      for (int w = 0; w < WPORTS; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[r])) begin
          w_rd_word[r] = bus.wr_data[w];
        end
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    for (int w = 0; w < WPORTS; w++) begin
      for (int r = 0; r < RPORTS; r++) begin
        if (w_we[w]) r_bank[w][r][w_waddr[w]] <= w_wdata[w];
      end
    end
  end

  // Later loop iterations override earlier ones, so the highest asserting port owns the entry.
  always_ff @(posedge i_clk) begin
    if (r_state == StInit) begin
      r_lvt[r_cnt] <= '0;
    end else begin
      for (int w = 0; w < WPORTS; w++) begin
        if (bus.wr_en[w]) r_lvt[bus.wr_addr[w]] <= LW'(w);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= StInit;
      r_cnt             <= '0;
      r_rd_data         <= '0;
      r_rd_valid        <= '0;
      r_init_done       <= 1'b0;
      r_collision       <= 1'b0;
      r_collision_count <= '0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_cnt       <= r_cnt + 1'b1;
          r_rd_valid  <= '0;
          r_collision <= 1'b0;
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state     <= StRun;
            r_init_done <= 1'b1;
          end
        end
        StRun: begin
          r_collision <= w_clash;
          if (w_clash && (r_collision_count != 16'hFFFF)) begin
            r_collision_count <= r_collision_count + 16'd1;
          end
          r_rd_valid <= bus.rd_en;
          for (int r = 0; r < RPORTS; r++) begin
            if (bus.rd_en[r]) r_rd_data[r] <= w_rd_word[r];
          end
        end
      endcase
    end
  end

  assign bus.rd_data         = r_rd_data;
  assign bus.rd_valid        = r_rd_valid;
  assign bus.init_done       = r_init_done;
  assign bus.collision       = r_collision;
  assign bus.collision_count = r_collision_count;
endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed scoreboard bench for lvt_multiport_ram (DEPTH=8, 4W4R, INIT_VALUE=A5A5A5A5).
`timescale 1ns/1ps
module tb_lvt_multiport_ram;
  localparam logic [31:0] InitV = 32'hA5A5A5A5;

  typedef struct {
    int          port;
    logic [31:0] data;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] model [8];

  lvt_multiport_ram_if #(.WIDTH(32), .DEPTH(8), .WPORTS(4), .RPORTS(4)) bus ();

  lvt_multiport_ram #(
    .WIDTH(32), .DEPTH(8), .WPORTS(4), .RPORTS(4), .INIT_VALUE(InitV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;
  endtask

  // One RUN-mode cycle: expectations come from the bench model before its writes land.
  task automatic cycle(input logic [3:0] wen, input logic [3:0][2:0] waddr,
                       input logic [3:0][31:0] wdata, input logic [3:0] ren,
                       input logic [3:0][2:0] raddr, input string tag);
    logic [31:0] v;
    exp_t        e;
    bus.wr_en   = wen;
    bus.wr_addr = waddr;
    bus.wr_data = wdata;
    bus.rd_en   = ren;
    bus.rd_addr = raddr;
    for (int r = 0; r < 4; r++) begin
      if (ren[r]) begin
        v = model[raddr[r]];
`ifdef LVT_WRITE_FORWARD_EN
        for (int w = 0; w < 4; w++) if (wen[w] && waddr[w] == raddr[r]) v = wdata[w];
`endif
        sb.push_back('{port: r, data: v, tag: tag});
      end
    end
    for (int w = 0; w < 4; w++) if (wen[w]) model[waddr[w]] = wdata[w];
    tick();
    idle_inputs();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_valid"}, 32'(bus.rd_valid[e.port]), 32'd1);
      check(e.tag, bus.rd_data[e.port], e.data);
    end
  endtask

  initial begin
    idle_inputs();
    for (int a = 0; a < 8; a++) model[a] = InitV;
    #2;
    check("rst_rd_data", bus.rd_data[0] | bus.rd_data[1] | bus.rd_data[2] | bus.rd_data[3], 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_init_done", 32'(bus.init_done), 0);
    check("rst_collision", 32'(bus.collision), 0);
    check("rst_count", 32'(bus.collision_count), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("init_done_edge%0d", i), 32'(bus.init_done), 32'(i == 8));
    end

    cycle('0, '0, '0, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, "init_rd_lo");
    cycle('0, '0, '0, 4'hF, {3'd7, 3'd6, 3'd5, 3'd4}, "init_rd_hi");

    cycle(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, {32'd0, 32'd0, 32'd0, 32'h11}, '0, '0, "w0");
    cycle(4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, {32'd0, 32'h22, 32'd0, 32'd0}, '0, '0, "w2");
    check("no_collision_seq", 32'(bus.collision), 0);
    cycle('0, '0, '0, 4'hF, {3'd3, 3'd3, 3'd3, 3'd3}, "rd_addr3");

    cycle(4'b1010, {3'd5, 3'd0, 3'd5, 3'd0}, {32'h44, 32'd0, 32'h33, 32'd0}, '0, '0, "clash5");
    check("collision_pulse", 32'(bus.collision), 1);
    check("collision_count1", 32'(bus.collision_count), 1);
    cycle('0, '0, '0, 4'hF, {3'd5, 3'd5, 3'd5, 3'd5}, "rd_addr5");
    check("collision_drop", 32'(bus.collision), 0);
    check("collision_count_hold", 32'(bus.collision_count), 1);

    cycle(4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, '0, '0, '0, "zero7");
    cycle(4'b0010, {3'd0, 3'd0, 3'd7, 3'd0}, {32'd0, 32'd0, 32'h99, 32'd0},
          4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, "rdw7");
    cycle('0, '0, '0, 4'hF, {3'd7, 3'd7, 3'd7, 3'd7}, "rd_addr7");
    cycle('0, '0, '0, '0, '0, "idle");
    check("hold_valid", 32'(bus.rd_valid), 0);
    check("hold_data", bus.rd_data[0], 32'h99);

    rst_n = 1'b0;
    #1;
    check("async_init_done", 32'(bus.init_done), 0);
    check("async_count", 32'(bus.collision_count), 0);
    check("async_rd_data", bus.rd_data[0], 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) model[a] = InitV;
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en   = 4'hF;
      bus.wr_addr = {4{3'(i - 1)}};
      bus.wr_data = {4{32'hDEAD0000 + 32'(i)}};
      bus.rd_en   = 4'hF;
      bus.rd_addr = {4{3'(i - 1)}};
      tick();
      check($sformatf("reinit_done%0d", i), 32'(bus.init_done), 32'(i == 8));
      check($sformatf("reinit_valid%0d", i), 32'(bus.rd_valid), 0);
      check($sformatf("reinit_coll%0d", i), 32'(bus.collision), 0);
    end
    idle_inputs();
    cycle('0, '0, '0, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, "reinit_rd_lo");
    cycle('0, '0, '0, 4'hF, {3'd7, 3'd6, 3'd5, 3'd4}, "reinit_rd_hi");
    check("reinit_count", 32'(bus.collision_count), 0);

    bus.wr_en   = 4'b0011;
    bus.wr_addr = '0;
    bus.wr_data = {32'd0, 32'd0, 32'h5A, 32'd0};
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (i == 2) check("count_after3", 32'(bus.collision_count), 3);
    end
    model[0] = 32'h5A;
    check("count_saturated", 32'(bus.collision_count), 32'h0000FFFF);
    check("collision_sustained", 32'(bus.collision), 1);
    cycle('0, '0, '0, 4'b0001, '0, "rd_after_sat");
    check("count_sat_hold", 32'(bus.collision_count), 32'h0000FFFF);
    check("collision_end", 32'(bus.collision), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lvt_multiport_ram.md
# lvt_multiport_ram

Parametrised multi-write, multi-read RAM built from a WPORTS×RPORTS grid of 1W1R banks and a live-value table (LVT) that records which write port last wrote each address. It generalises the symmetric read/write-port LVT memory to independent write and read port counts, adds a post-reset initialisation sweep, and defines same-cycle write-collision arbitration and statistics. It sits between the particle-update pipelines (writers) and the gather stages (readers).

## Interface
- WIDTH, 32, data word width
- DEPTH, 512, words per port view; power of two, ≥2
- WPORTS, 4, write ports, ≥2
- RPORTS, 4, read ports, ≥1
- INIT_VALUE, 0, WIDTH-bit value written to every address during the init sweep
- clk  in  1  sole clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1 [WPORTS]  write request per port
- wr_addr  in  clog2(DEPTH) [WPORTS]  write address
- wr_data  in  WIDTH [WPORTS]  write data
- rd_en  in  1 [RPORTS]  read request per port
- rd_addr  in  clog2(DEPTH) [RPORTS]  read address
- rd_data  out  WIDTH [RPORTS]  registered read data
- rd_valid  out  1 [RPORTS]  rd_data qualifier
- init_done  out  1  high once the init sweep has finished
- collision  out  1  pulses one cycle after any same-cycle same-address write clash
- collision_count  out  16  saturating count of clash cycles

## Operation
- Banks: bank[w][r] is 1W1R, written by write port w, read by read port r. LVT: DEPTH entries of max(1,clog2(WPORTS)) bits, flop-based, written by all write ports, read by all read ports.
- FSM states: INIT, RUN. Reset enters INIT with sweep counter = 0.
- INIT: each cycle writes INIT_VALUE to address=counter in every bank and 0 to LVT[counter]; counter increments; at counter = DEPTH-1 the next state is RUN and init_done goes high. User wr_en and rd_en are ignored (rd_valid stays 0, no collision accounting).
- RUN: for each w with wr_en[w], bank[w][*][wr_addr[w]] <= wr_data[w]. The LVT entry for an address written by several ports in the same cycle takes the highest asserting port index; that port's data is the surviving value. The losing ports' banks are still written but are never selected.
- Collision: any pair of asserted write ports with equal addresses in one cycle sets collision=1 for the next cycle and increments collision_count (one per cycle regardless of clash count), saturating at 16'hFFFF.
- Read: rd_data[r] <= bank[LVT[rd_addr[r]]][r][rd_addr[r]]; rd_valid[r] <= rd_en[r]. When rd_en[r]=0, rd_data[r] holds its previous value.
- Read-during-write, same address, same cycle: returns the old (pre-write) value unless forwarding is compiled in.
- Address range is exact power of two; no wrap handling is needed beyond natural truncation.

## Timing
- Reset values: rd_data all 0, rd_valid all 0, init_done 0, collision 0, collision_count 0, state INIT, counter 0.
- Init length: exactly DEPTH cycles; the first edge with rst_n high writes address 0; init_done is 1 after the DEPTH-th edge.
- Write to read visibility: a write in cycle N is visible to a read issued in cycle N+1.
- Read latency: 1 cycle (request on edge N, data and rd_valid valid after edge N+1's setup, i.e. sampled at edge N+1).
- rst_n low at any time, including mid-sweep, restarts INIT from address 0 and clears all outputs asynchronously.
- collision_count does not clear except on reset.

## Configuration
- LVT_WRITE_FORWARD_EN defined: a read in cycle N to an address also written in cycle N returns the winning write's wr_data (highest port index) at rd_data in cycle N+1.
- Undefined: the same read returns the value stored before cycle N.

## Test plan
- Reset then DEPTH=8, INIT_VALUE=32'hA5A5A5A5: init_done rises after exactly 8 edges; reads of all 8 addresses return 32'hA5A5A5A5 with rd_valid=1 one cycle after rd_en.
- Port 0 writes 0x11 to addr 3, next cycle port 2 writes 0x22 to addr 3; then every read port reads addr 3 -> 0x22.
- Ports 1 and 3 write 0x33 and 0x44 to addr 5 same cycle -> reads return 0x44; collision=1 for one cycle; collision_count=1.
- Read and write addr 7 (old value 0x0, new 0x99) same cycle -> rd_data 0x0 without LVT_WRITE_FORWARD_EN, 0x99 with it.
- Assert rst_n low at init address 4, release -> init_done stays 0 for a full DEPTH cycles; user writes during INIT have no effect.
- 65540 consecutive clash cycles -> collision_count saturates at 16'hFFFF.
